dw_piso_tx: RTL and testbench

Parallel-in/serial-out transmitter: the sending end of the serial-in/parallel-out shift-register path in the DW03 shift-register family. Accepts a `length`-bit word over a valid/ready handshake and emits it one bit per enabled cycle on `s_out`, with a per-bit valid and a first-bit frame strobe. Sits between a word-oriented producer and a serial link whose far end reassembles words in a shift register.

---
 rtl/dw_piso_pkg.sv | 11 +
 rtl/dw_piso_tx.sv | 86 ++++++++
 tb/tb_dw_piso_tx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dw_piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
package dw_piso_pkg;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} piso_state_t;

   // Bit-counter width for a word of len bits (len >= 2).
   function automatic int cnt_w(input int len);
      return $clog2(len);
   endfunction

endpackage

// File: rtl/dw_piso_tx.sv
// Parallel-in/serial-out transmitter: takes a word on a valid/ready handshake
// and emits it one bit per enabled cycle with per-bit valid and first-bit strobe.
module dw_piso_tx
   import dw_piso_pkg::*;
#(
   parameter int length    = 4,
   parameter bit msb_first = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [length-1:0] p_in,
   input  logic              p_valid,
   output logic              p_ready,
   input  logic              s_en,
   output logic              s_out,
   output logic              s_valid,
   output logic              s_frame
);

   localparam int            CW   = cnt_w(length);
   localparam logic [CW-1:0] LAST = CW'(length - 1);

   piso_state_t       state_q, state_d;
   logic [length-1:0] shreg_q, shreg_d, shreg_shift;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              s_out_q, s_valid_q, s_frame_q;
   logic              out_bit_d, last_bit, retire, accept;

   // One last-bit term shared by the ready and next-state logic.
   assign last_bit = (cnt_q == LAST);
   assign retire   = (state_q == SHIFT) & s_en;
   assign p_ready  = !rst & ((state_q == IDLE) | (retire & last_bit));
   assign accept   = p_valid & p_ready;

   generate
      if (msb_first) begin : g_msb
         assign shreg_shift = {shreg_q[length-2:0], 1'b0};
         assign out_bit_d   = shreg_d[length-1];
      end else begin : g_lsb
         assign shreg_shift = {1'b0, shreg_q[length-1:1]};
         assign out_bit_d   = shreg_d[0];
      end
   endgenerate

   // A handshake on the last-bit cycle reloads directly: no idle bit between words.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         shreg_d = p_in;
         cnt_d   = '0;
         state_d = SHIFT;
      end else if (retire) begin
         if (last_bit) begin
            state_d = IDLE;
         end else begin
            shreg_d = shreg_shift;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         s_out_q   <= 1'b0;
         s_valid_q <= 1'b0;
         s_frame_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         s_valid_q <= (state_d == SHIFT);
         s_out_q   <= (state_d == SHIFT) & out_bit_d;
         s_frame_q <= (state_d == SHIFT) & (cnt_d == '0);
      end
   end

   assign s_out   = s_out_q;
   assign s_valid = s_valid_q;
   assign s_frame = s_frame_q;

endmodule

// File: tb/tb_dw_piso_tx.sv
// Directed bench for dw_piso_tx: MSB-first and LSB-first instances share stimulus.
module tb_dw_piso_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] p_in;
   logic       p_valid;
   logic       s_en;
   logic       rdy_m, so_m, sv_m, sf_m;
   logic       rdy_l, so_l, sv_l, sf_l;
   int         cmp = 0;
   int         err = 0;

   always #5 clk = ~clk;

   dw_piso_tx #(.length(4), .msb_first(1'b1)) u_msb (
      .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(rdy_m),
      .s_en(s_en), .s_out(so_m), .s_valid(sv_m), .s_frame(sf_m));

   dw_piso_tx #(.length(4), .msb_first(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(rdy_l),
      .s_en(s_en), .s_out(so_l), .s_valid(sv_l), .s_frame(sf_l));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; p_valid = 1'b1; p_in = 4'hF; s_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         #1;
         cmp++;
         if ({rdy_m, sv_m, sf_m, so_m} !== 4'b0000) begin
            err++;
            $display("FAIL reset_hold[%0d] got rdy/v/f/o=%b want 0000", i, {rdy_m, sv_m, sf_m, so_m});
         end
      end
      rst = 1'b0;
      #1;
      cmp++;
      if (rdy_m !== 1'b1) begin
         err++;
         $display("FAIL reset_release_ready got %b want 1", rdy_m);
      end
      tick();
      p_valid = 1'b0;
      #1;
      cmp++;
      if ({sv_m, sf_m, so_m} !== 3'b111) begin
         err++;
         $display("FAIL reset_first_accept got v/f/o=%b want 111", {sv_m, sf_m, so_m});
      end
      repeat (4) tick();
      cmp++;
      if (sv_m !== 1'b0) begin
         err++;
         $display("FAIL reset_drain got s_valid=%b want 0", sv_m);
      end
   endtask

   task automatic test_single_word();
      logic [3:0] exp;
      exp = 4'b1011;
      p_in = 4'b1011; p_valid = 1'b1; s_en = 1'b1;
      tick();
      p_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         cmp++;
         if ({sv_m, sf_m, so_m} !== {1'b1, (i == 0), exp[3-i]}) begin
            err++;
            $display("FAIL single_bit[%0d] got v/f/o=%b want %b", i, {sv_m, sf_m, so_m}, {1'b1, (i == 0), exp[3-i]});
         end
         tick();
      end
      #1;
      cmp++;
      if ({sv_m, rdy_m} !== 2'b01) begin
         err++;
         $display("FAIL single_idle got v/rdy=%b want 01", {sv_m, rdy_m});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      exp = 8'b1010_0101;
      p_in = 4'hA; p_valid = 1'b1; s_en = 1'b1;
      tick();
      p_in = 4'h5;
      for (int i = 0; i < 8; i++) begin
         p_valid = (i < 4);
         #1;
         cmp++;
         if ({sv_m, sf_m, so_m, rdy_m} !== {1'b1, (i % 4 == 0), exp[7-i], (i % 4 == 3)}) begin
            err++;
            $display("FAIL b2b_bit[%0d] got v/f/o/rdy=%b want %b", i, {sv_m, sf_m, so_m, rdy_m},
                     {1'b1, (i % 4 == 0), exp[7-i], (i % 4 == 3)});
         end
         tick();
      end
      #1;
      cmp++;
      if (sv_m !== 1'b0) begin
         err++;
         $display("FAIL b2b_idle got s_valid=%b want 0", sv_m);
      end
   endtask

   task automatic test_stall();
      p_in = 4'b1100; p_valid = 1'b1; s_en = 1'b1;
      tick();
      p_valid = 1'b0;
      #1;
      cmp++;
      if ({sv_m, sf_m, so_m} !== 3'b111) begin
         err++;
         $display("FAIL stall_bit0 got v/f/o=%b want 111", {sv_m, sf_m, so_m});
      end
      tick();
      s_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         cmp++;
         if ({sv_m, sf_m, so_m, rdy_m, u_msb.cnt_q} !== 6'b101_0_01) begin
            err++;
            $display("FAIL stall_bit1[%0d] got v/f/o/rdy/cnt=%b want 101001", i, {sv_m, sf_m, so_m, rdy_m, u_msb.cnt_q});
         end
         tick();
      end
      s_en = 1'b1;
      tick();
      #1;
      cmp++;
      if ({sv_m, so_m, u_msb.cnt_q} !== 4'b10_10) begin
         err++;
         $display("FAIL stall_bit2 got v/o/cnt=%b want 1010", {sv_m, so_m, u_msb.cnt_q});
      end
      tick();
      s_en = 1'b0; p_valid = 1'b1; p_in = 4'hF;
      for (int i = 0; i < 2; i++) begin
         #1;
         cmp++;
         if ({sv_m, so_m, rdy_m, u_msb.cnt_q} !== 5'b100_11) begin
            err++;
            $display("FAIL stall_bit3[%0d] got v/o/rdy/cnt=%b want 10011", i, {sv_m, so_m, rdy_m, u_msb.cnt_q});
         end
         tick();
      end
      s_en = 1'b1; p_valid = 1'b0;
      #1;
      cmp++;
      if ({so_m, rdy_m} !== 2'b01) begin
         err++;
         $display("FAIL stall_release got o/rdy=%b want 01", {so_m, rdy_m});
      end
      tick();
      #1;
      cmp++;
      if (sv_m !== 1'b0) begin
         err++;
         $display("FAIL stall_idle got s_valid=%b want 0", sv_m);
      end
   endtask

   task automatic test_lsb_first();
      logic [3:0] exp;
      exp = 4'b0001;
      p_in = 4'b0001; p_valid = 1'b1; s_en = 1'b1;
      tick();
      p_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         cmp++;
         if ({sv_l, sf_l, so_l} !== {1'b1, (i == 0), (i == 0)}) begin
            err++;
            $display("FAIL lsb_bit[%0d] got v/f/o=%b want %b", i, {sv_l, sf_l, so_l}, {1'b1, (i == 0), exp[i]});
         end
         tick();
      end
      #1;
      cmp++;
      if (sv_l !== 1'b0) begin
         err++;
         $display("FAIL lsb_idle got s_valid=%b want 0", sv_l);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [3:0] exp;
      exp = 4'b0011;
      p_in = 4'hA; p_valid = 1'b1; s_en = 1'b1;
      tick();
      p_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1; p_valid = 1'b1; p_in = 4'h3;
      #1;
      cmp++;
      if (rdy_m !== 1'b0) begin
         err++;
         $display("FAIL midrst_ready got %b want 0", rdy_m);
      end
      tick();
      rst = 1'b0;
      #1;
      cmp++;
      if ({sv_m, sf_m, so_m, rdy_m} !== 4'b0001) begin
         err++;
         $display("FAIL midrst_after got v/f/o/rdy=%b want 0001", {sv_m, sf_m, so_m, rdy_m});
      end
      tick();
      p_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         cmp++;
         if ({sv_m, sf_m, so_m} !== {1'b1, (i == 0), exp[3-i]}) begin
            err++;
            $display("FAIL midrst_bit[%0d] got v/f/o=%b want %b", i, {sv_m, sf_m, so_m}, {1'b1, (i == 0), exp[3-i]});
         end
         tick();
      end
      #1;
      cmp++;
      if (sv_m !== 1'b0) begin
         err++;
         $display("FAIL midrst_idle got s_valid=%b want 0", sv_m);
      end
   endtask

   initial begin
      rst = 1'b1; p_in = '0; p_valid = 1'b0; s_en = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall();
      test_lsb_first();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule
